// File: rtl/hier_leaf_pkg.sv
// Shared defaults and the pointer-increment helper for the hier_leaf buffering stage.
package hier_leaf_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;
  localparam int POP_CNT_W      = 16;

  // depth is a power of two, so the modulo reduces to a mask
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr + 32'd1) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/hier_leaf_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port, no reset.
module hier_leaf_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hier_leaf_fifo.sv
// Leaf FIFO: valid/ready in and out, DEPTH-word ordered storage, running XOR checksum and pop counter.
module hier_leaf_fifo
  import hier_leaf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          checksum,
  output logic [POP_CNT_W-1:0]       pop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]    checksum_q, checksum_d;
  logic [POP_CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic                 push_s, pop_s, wr_en_s;
  logic [DATA_W-1:0]    rd_data_s;

  // Handshake decode only from registered occupancy: no in_valid/out_ready to ready/valid path.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != {CNT_W{1'b0}});
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign wr_en_s   = push_s & ~flush;

  hier_leaf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  assign out_data = out_valid ? rd_data_s : {DATA_W{1'b0}};
  assign count    = count_q;
  assign checksum = checksum_q;
  assign pop_cnt  = pop_cnt_q;

  // Next-state for pointers, occupancy and traffic statistics; flush overrides any handshake.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    pop_cnt_d  = pop_cnt_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d   = PTR_W'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
        checksum_d = checksum_q ^ out_data;
        pop_cnt_d  = pop_cnt_q + {{(POP_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      checksum_q <= {DATA_W{1'b0}};
      pop_cnt_q  <= {POP_CNT_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

endmodule
